// File: rtl/dff_pipe_pkg.sv
// Shared defaults and sizing helper for the dff_pipe elastic register chain.
package dff_pipe_pkg;

  localparam int unsigned DefWidth    = 8;
  localparam int unsigned DefDepth    = 4;
  localparam int unsigned DefResetVal = 0;

  // Bits needed to count 0..depth valid stages.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One elastic pipeline slot: valid bit plus data word, with load, drain and clear.
module dff_stage
  import dff_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = DefWidth,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DefResetVal)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             drain_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Clear wins over load so a flush never disturbs the stored data word.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/dff_pipe.sv
// Elastic valid/ready register chain of DEPTH stages with flush and occupancy count.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = DefWidth,
  parameter int unsigned      DEPTH     = DefDepth,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DefResetVal)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               out_data,
  input  logic                           out_ready,
  input  logic                           flush,
  output logic [occ_width(DEPTH)-1:0]    occupancy
);

  localparam int unsigned OccW = occ_width(DEPTH);

  logic [DEPTH-1:0] stage_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] drain;
  logic [DEPTH:0]   src_v;
  logic             in_ok;
  logic             nxt_rdy;
  logic             stage_rdy;
  logic             in_xfer;
  logic             out_xfer;
  logic [OccW-1:0]  occ_q, occ_d;

  assign in_ok = in_valid & ~flush & rst_n;

  // Ready ripples from the output back to the input so a full chain streams without bubbles.
  always_comb begin
    load      = '0;
    drain     = '0;
    src_v     = {stage_valid, in_ok};
    nxt_rdy   = out_ready;
    stage_rdy = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      drain[k]  = stage_valid[k] & nxt_rdy;
      stage_rdy = ~stage_valid[k] | drain[k];
      load[k]   = src_v[k] & stage_rdy;
      nxt_rdy   = stage_rdy;
    end
    in_ready = rst_n & ~flush & nxt_rdy;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] src_data;
    if (k == 0) begin : g_first
      assign src_data = in_data;
    end else begin : g_rest
      assign src_data = stage_data[k-1];
    end

    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load[k]),
      .drain_i (drain[k]),
      .clear_i (flush),
      .data_i  (src_data),
      .valid_o (stage_valid[k]),
      .data_o  (stage_data[k])
    );
  end

  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q + OccW'(in_xfer) - OccW'(out_xfer);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed, table-driven bench for dff_pipe (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5) plus a DEPTH=1 copy.
module tb_dff_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       flush;
  logic [2:0] occupancy;

  logic       iv1;
  logic [7:0] id1;
  logic       ir1;
  logic       ov1;
  logic [7:0] od1;
  logic       or1;
  logic [0:0] occ1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  logic       hold_prev = 1'b0;
  logic [7:0] data_prev = '0;

  dff_pipe #(
    .WIDTH     (8),
    .DEPTH     (4),
    .RESET_VAL (8'hA5)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .occupancy (occupancy)
  );

  dff_pipe #(
    .WIDTH     (8),
    .DEPTH     (1),
    .RESET_VAL (8'h5A)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv1),
    .in_data   (id1),
    .in_ready  (ir1),
    .out_valid (ov1),
    .out_data  (od1),
    .out_ready (or1),
    .flush     (1'b0),
    .occupancy (occ1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       r;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [2:0] e_occ;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic iv, logic [7:0] d, logic ordy, logic fl,
                              logic e_ir, logic e_ov, logic [7:0] e_od, logic [2:0] e_occ);
    vec_t v;
    v.r = r; v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [7:0] d, input logic ordy,
                       input logic fl);
    rst_n     = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for out_valid, then checks the word and how many edges it took.
  task automatic expect_out(input logic [7:0] exp, input int exp_lat, input string nm);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #2;
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    chk({nm, " seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({nm, " data"}, 32'(out_data), 32'(exp));
      chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    end
  endtask

  // Output must hold while stalled; occupancy bounded; full and stalled blocks input.
  initial begin
    forever begin
      @(posedge clk);
      hold_prev = rst_n && out_valid && !out_ready;
      data_prev = out_data;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("mon occupancy_le_4", 32'(occupancy <= 3'd4), 32'd1);
        if (occupancy == 3'd4 && !out_ready) chk("mon full_in_ready", 32'(in_ready), 32'd0);
        if (hold_prev) chk("mon out_data_stable", 32'(out_data), 32'(data_prev));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    iv1 = 1'b0; id1 = '0; or1 = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    mon_en = 1'b1;

    // reset, streaming, backpressure
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'hA5, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 1, 0, 8'hA5, 0));
    vecs.push_back(mk(1, 1, 8'h01, 1, 0, 1, 0, 8'hA5, 0));
    vecs.push_back(mk(1, 1, 8'h02, 1, 0, 1, 0, 8'hA5, 1));
    vecs.push_back(mk(1, 1, 8'h03, 1, 0, 1, 0, 8'hA5, 2));
    vecs.push_back(mk(1, 1, 8'h04, 1, 0, 1, 0, 8'hA5, 3));
    vecs.push_back(mk(1, 1, 8'h05, 1, 0, 1, 1, 8'h01, 4));
    vecs.push_back(mk(1, 1, 8'h06, 1, 0, 1, 1, 8'h02, 4));
    vecs.push_back(mk(1, 1, 8'h07, 1, 0, 1, 1, 8'h03, 4));
    vecs.push_back(mk(1, 1, 8'h08, 1, 0, 1, 1, 8'h04, 4));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 1, 1, 8'h05, 4));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 1, 1, 8'h06, 3));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 1, 1, 8'h07, 2));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 1, 1, 8'h08, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 1, 0, 8'h08, 0));
    vecs.push_back(mk(1, 1, 8'h11, 0, 0, 1, 0, 8'h08, 0));
    vecs.push_back(mk(1, 1, 8'h12, 0, 0, 1, 0, 8'h08, 1));
    vecs.push_back(mk(1, 1, 8'h13, 0, 0, 1, 0, 8'h08, 2));
    vecs.push_back(mk(1, 1, 8'h14, 0, 0, 1, 0, 8'h08, 3));
    vecs.push_back(mk(1, 1, 8'h15, 0, 0, 0, 1, 8'h11, 4));
    vecs.push_back(mk(1, 1, 8'h16, 0, 0, 0, 1, 8'h11, 4));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 8'h11, 4));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 1, 1, 8'h11, 4));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 1, 1, 8'h12, 3));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 1, 1, 8'h13, 2));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 1, 1, 8'h14, 1));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 1, 0, 8'h14, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      #2;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].e_od));
      chk($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
      tick();
    end

    // flush with three words in flight and a concurrent input
    drive(1, 1, 8'h21, 0, 0); tick();
    drive(1, 1, 8'h22, 0, 0); tick();
    drive(1, 1, 8'h23, 0, 0); tick();
    drive(1, 1, 8'h24, 0, 1);
    #2;
    chk("flush in_ready", 32'(in_ready), 32'd0);
    chk("flush pre occupancy", 32'(occupancy), 32'd3);
    tick();
    drive(1, 0, 8'h00, 0, 0);
    #2;
    chk("flush post occupancy", 32'(occupancy), 32'd0);
    chk("flush post out_valid", 32'(out_valid), 32'd0);
    chk("flush post out_data held", 32'(out_data), 32'h14);
    chk("flush post in_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1, 1, 8'h25, 1, 0); tick();
    drive(1, 0, 8'h00, 1, 0);
    expect_out(8'h25, 3, "after flush");
    tick();
    #2;
    chk("after flush drained", 32'(out_valid), 32'd0);

    // reset while full
    drive(1, 1, 8'h31, 0, 0); tick();
    drive(1, 1, 8'h32, 0, 0); tick();
    drive(1, 1, 8'h33, 0, 0); tick();
    drive(1, 1, 8'h34, 0, 0); tick();
    drive(1, 0, 8'h00, 0, 0);
    #2;
    chk("full occupancy", 32'(occupancy), 32'd4);
    chk("full out_data", 32'(out_data), 32'h31);
    chk("full in_ready", 32'(in_ready), 32'd0);
    drive(0, 1, 8'h35, 1, 1);
    #2;
    chk("in reset in_ready", 32'(in_ready), 32'd0);
    tick();
    drive(1, 0, 8'h00, 0, 0);
    #2;
    chk("post reset out_valid", 32'(out_valid), 32'd0);
    chk("post reset out_data", 32'(out_data), 32'hA5);
    chk("post reset occupancy", 32'(occupancy), 32'd0);
    chk("post reset in_ready", 32'(in_ready), 32'd1);
    chk("d1 post reset out_data", 32'(od1), 32'h5A);
    drive(1, 1, 8'h3C, 1, 0); tick();
    drive(1, 0, 8'h00, 1, 0);
    expect_out(8'h3C, 3, "after reset");
    tick();

    // single-stage buffer
    iv1 = 1'b1; id1 = 8'h77; or1 = 1'b0;
    #2;
    chk("d1 empty in_ready", 32'(ir1), 32'd1);
    chk("d1 empty out_valid", 32'(ov1), 32'd0);
    tick();
    id1 = 8'h78;
    #2;
    chk("d1 full in_ready", 32'(ir1), 32'd0);
    chk("d1 full out_data", 32'(od1), 32'h77);
    chk("d1 full occupancy", 32'(occ1), 32'd1);
    tick();
    or1 = 1'b1;
    #2;
    chk("d1 pass in_ready", 32'(ir1), 32'd1);
    chk("d1 held out_data", 32'(od1), 32'h77);
    tick();
    iv1 = 1'b0;
    #2;
    chk("d1 next out_valid", 32'(ov1), 32'd1);
    chk("d1 next out_data", 32'(od1), 32'h78);
    tick();
    #2;
    chk("d1 drained", 32'(ov1), 32'd0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
